// File: rtl/uart_tx_sched.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration.
// A byte is accepted only in IDLE; the frame then runs to completion unless reset.
module uart_tx_sched #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(BAUD_DIV - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_last_grant;
  logic        r_tx;
  logic        r_busy;
  logic        r_grant_id;
  logic        r_frame_done;

  logic w_idle;
  logic w_rdy0;
  logic w_rdy1;
  logic w_bit_end;

  // Handshake: a byte moves on any cycle where valid && ready. Ready is
  // combinational, only ever high in IDLE outside reset, and at most one
  // requester sees it; when both are valid the one not granted last wins.
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_rdy0    = w_idle && req0_valid && (!req1_valid || r_last_grant);
  assign w_rdy1    = w_idle && req1_valid && (!req0_valid || !r_last_grant);
  assign w_bit_end = (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_last_grant <= 1'b1;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_grant_id   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_rdy0 || w_rdy1) begin
            r_shift      <= w_rdy1 ? req1_data : req0_data;
            r_last_grant <= w_rdy1;
            r_grant_id   <= w_rdy1;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              // tx already shows r_shift[0]; next bit is r_shift[1]
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: arbitration table, serial frame decoding against an
// expected-frame queue, contention, lone requester, mid-frame reset, default baud.
module tb_uart_tx_sched;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx, busy, grant_id, frame_done;
  logic [1:0] dbg_state;

  logic       s_v0, s_v1;
  logic [7:0] s_d0, s_d1;
  logic       s_r0, s_r1, s_tx, s_busy, s_gid, s_fd;
  logic [1:0] s_dbg;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_sched #(.BAUD_DIV(B)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  uart_tx_sched u_slow (
    .clk(clk), .rst(rst),
    .req0_valid(s_v0), .req0_data(s_d0), .req0_ready(s_r0),
    .req1_valid(s_v1), .req1_data(s_d1), .req1_ready(s_r1),
    .tx(s_tx), .busy(s_busy), .grant_id(s_gid), .frame_done(s_fd),
    .dbg_state(s_dbg)
  );

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge just before the transfer edge; samples the 40 frame
  // cycles, decodes the byte, then checks the idle cycle that follows.
  task automatic run_frame(input bit hold);
    logic [39:0] s;
    logic [7:0]  rx;
    logic [8:0]  exp;
    logic        gid;
    int          bad_ctl;
    int          bad_shape;
    bad_ctl = 0;
    bad_shape = 0;
    gid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s[i] = tx;
      if (i == 0) gid = grant_id;
      if (!busy || frame_done || req0_ready || req1_ready || grant_id !== gid) bad_ctl++;
      if (!hold) begin
        req0_data = 8'($urandom_range(0, 255));
        req1_data = 8'($urandom_range(0, 255));
        if (i == 39) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end else begin
          req0_valid = 1'($urandom_range(0, 1));
          req1_valid = 1'($urandom_range(0, 1));
        end
      end
    end
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < B; c++)
        if (s[k*B+c] !== s[k*B+2]) bad_shape++;
    for (int b = 0; b < 8; b++) rx[b] = s[(b+1)*B+2];
    chk("frame_ctl", 32'(bad_ctl), 32'd0);
    chk("frame_shape", 32'(bad_shape), 32'd0);
    chk("start_bit", 32'(s[2]), 32'd0);
    chk("stop_bit", 32'(s[38]), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got frame %0h expected none queued", rx);
    end else begin
      exp = exp_q.pop_front();
      chk("frame_data", 32'(rx), 32'(exp[7:0]));
      chk("grant_id", 32'(gid), 32'(exp[8]));
    end
    @(negedge clk);
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (s_tx === lvl && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] lone[3];
    int n;
    lone[0] = 8'h3A; lone[1] = 8'hC5; lone[2] = 8'h0F;

    // Arbitration table; last_grant starts at 1 after reset.
    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h81, 8'h7E, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    s_v0 = 1'b0; s_v1 = 1'b0; s_d0 = 8'h00; s_d1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      req0_data  = vecs[i].d0; req1_data  = vecs[i].d1;
      @(negedge clk);
      chk("tbl_rdy0", 32'(req0_ready), 32'(vecs[i].r0));
      chk("tbl_rdy1", 32'(req1_ready), 32'(vecs[i].r1));
      exp_q.push_back({vecs[i].r1, vecs[i].r1 ? vecs[i].d1 : vecs[i].d0});
      run_frame(1'b0);
    end

    // Contention: last grant was requester 1, so 0,1,0 with one idle cycle between.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h11; req1_data = 8'h22;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      chk("ct_rdy0", 32'(req0_ready), 32'(f != 1));
      chk("ct_rdy1", 32'(req1_ready), 32'(f == 1));
      exp_q.push_back((f == 1) ? {1'b1, 8'h22} : {1'b0, 8'h11});
      run_frame(1'b1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Lone requester 1 held valid: accepted back-to-back every frame.
    @(posedge clk);
    #1;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      req1_data = lone[j];
      chk("lone_rdy1", 32'(req1_ready), 32'd1);
      chk("lone_rdy0", 32'(req0_ready), 32'd0);
      exp_q.push_back({1'b1, lone[j]});
      run_frame(1'b1);
    end
    req1_valid = 1'b0;

    // Reset during cycle 15 of a frame.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_data = 8'h3C;
    @(negedge clk);
    chk("mr_rdy0", 32'(req0_ready), 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 8'h96; req1_data = 8'h69;
    @(negedge clk);
    chk("mr_busy_pre", 32'(busy), 32'd1);
    chk("mr_rdy_in_rst", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    chk("mr_tx", 32'(tx), 32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_fd", 32'(frame_done), 32'd0);
    chk("mr_rdy_in_rst2", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_fd_after", 32'(frame_done), 32'd0);
    chk("mr_rdy0_after", 32'(req0_ready), 32'd1);
    chk("mr_rdy1_after", 32'(req1_ready), 32'd0);
    exp_q.push_back({1'b0, 8'h96});
    run_frame(1'b0);

    // Default baud divisor: first three bit periods of 8'h55.
    @(posedge clk);
    #1;
    s_v0 = 1'b1; s_d0 = 8'h55;
    @(negedge clk);
    chk("slow_rdy0", 32'(s_r0), 32'd1);
    @(posedge clk);
    #1;
    s_v0 = 1'b0;
    @(negedge clk);
    count_level(1'b0, n);
    chk("slow_start_len", 32'(n), 32'd10416);
    count_level(1'b1, n);
    chk("slow_bit0_len", 32'(n), 32'd10416);
    count_level(1'b0, n);
    chk("slow_bit1_len", 32'(n), 32'd10416);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 10416, meaning clock cycles per serial bit (9600 baud at 100 MHz); legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port req0_valid  input  1  requester 0 has a byte to send.
REQ-005 SHALL provide port req0_data  input  8  requester 0 byte.
REQ-006 SHALL provide port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 SHALL provide port req1_valid  input  1  requester 1 has a byte to send.
REQ-008 SHALL provide port req1_data  input  8  requester 1 byte.
REQ-009 SHALL provide port req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 SHALL provide port tx  output  1  serial line, 8N1, idle high.
REQ-011 SHALL provide port busy  output  1  frame in progress (state != IDLE).
REQ-012 SHALL provide port grant_id  output  1  requester owning current/last frame.
REQ-013 SHALL provide port frame_done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-014 SHALL implement states IDLE, START, DATA, STOP; tx, busy, grant_id, frame_done registered.
REQ-015 In IDLE, req0_ready SHALL be combinational: IDLE && req0_valid && (!req1_valid || last_grant==1); req1_ready symmetric (IDLE && req1_valid && (!req0_valid || last_grant==0)).
REQ-016 A transfer SHALL occur on a cycle where valid && ready; at most one ready high per cycle; ready SHALL be 0 outside IDLE.
REQ-017 On transfer the selected byte SHALL be latched into a shift register, last_grant and grant_id set to the winner, baud counter cleared, state -> START.
REQ-018 Round-robin: with both valid in IDLE, the requester not in last_grant SHALL win; a lone valid requester SHALL win regardless of last_grant.
REQ-019 Baud counter SHALL count 0..BAUD_DIV-1 in START/DATA/STOP; bit_end when count==BAUD_DIV-1, then wrap to 0.
REQ-020 tx SHALL be 0 for BAUD_DIV cycles beginning the cycle after transfer (START); state -> DATA on bit_end.
REQ-021 DATA SHALL emit 8 bits LSB first, each BAUD_DIV cycles, via 3-bit bit index; after bit 7 bit_end, state -> STOP.
REQ-022 STOP SHALL drive tx=1 for BAUD_DIV cycles; on bit_end state -> IDLE and frame_done=1 for exactly the next cycle.
REQ-023 Frame SHALL be 10*BAUD_DIV cycles of tx activity; earliest next transfer is the first IDLE cycle after STOP (1 idle cycle min between frames).
REQ-024 Input data/valid changes during a frame SHALL NOT affect the frame in progress.
REQ-025 tx SHALL be 1 in IDLE; no glitch on tx (registered only).

Reset
REQ-026 With rst=1 at a clock edge: state=IDLE, tx=1, busy=0, frame_done=0, grant_id=0, last_grant=1 (req0 wins first tie), counter=0, bit index=0, shift reg=0.
REQ-027 rst SHALL override all activity, including mid-frame: tx=1 the cycle after the reset edge, frame aborted, no frame_done, no ready while rst=1.

Verification (BAUD_DIV=4 unless noted)
REQ-028 Reset: hold rst 2 cycles -> tx=1, busy=0, ready=0, grant_id=0.
REQ-029 Single byte: req0_valid, data=8'hA5 -> req0_ready 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; frame_done 1 cycle after 40 cycles; busy high 40 cycles.
REQ-030 Contention: both valid continuously, req0=8'h11, req1=8'h22 -> frames alternate req0,req1,req0; grant_id 0,1,0; 1 idle cycle between frames.
REQ-031 Lone requester: only req1_valid, 3 bytes -> all accepted by req1 back-to-back, grant_id=1 each.
REQ-032 Reset mid-frame: rst at cycle 15 of a frame -> tx=1 next cycle, busy=0, no frame_done; next request after release starts fresh frame with req0 priority.
REQ-033 Default BAUD_DIV=10416: one frame 8'h55 -> each bit exactly 10416 cycles, frame 104160 cycles.
